// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Instruction fetch unit. Owns the PC, issues one instruction
//                memory request at a time (valid/ready request, valid-only
//                response) and holds the fetched word until the core commits
//                it via pc_update / next_pc.
//                Optional macro IFU_ALIGN_CHECK_EN: a misaligned PC raises
//                fetch_fault instead of issuing a request.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic        fetch_fault
);

    // Counter is 8 bits unless the timeout needs more range.
    localparam int unsigned     CNT_W       = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic             r_inst_valid;
    logic             r_fault;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;
    logic             w_misaligned;
    logic             w_req_fire;

`ifdef IFU_ALIGN_CHECK_EN
    assign w_misaligned  = (r_pc[1:0] != 2'b00);
    assign imem_req_addr = r_pc;
`else
    assign w_misaligned  = 1'b0;
    assign imem_req_addr = {r_pc[31:2], 2'b00};
`endif

    // Request is held low while in reset so memory never sees a request
    // during the reset cycles; it rises the first cycle after rst drops.
    assign imem_req_valid = (r_state == S_REQ) && !w_misaligned && !rst;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Saturating increment; timeout fires on the WAIT cycle that would bring
    // the count up to TIMEOUT_CYCLES, i.e. after exactly TIMEOUT_CYCLES waits.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_VAL);

    assign pc          = r_pc;
    assign instruction = r_inst;
    assign inst_valid  = r_inst_valid;
    assign fetch_fault = r_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: response beats timeout; pc_update only matters in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_misaligned) begin
                    w_state_nxt = S_HOLD;
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid || w_timeout) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pc_update) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // PC, held instruction, status flags and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        r_inst       <= NOP_INST;
                        r_fault      <= 1'b1;
                        r_inst_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (imem_rsp_valid) begin
                        r_inst       <= imem_rsp_err ? NOP_INST : imem_rsp_data;
                        r_fault      <= imem_rsp_err;
                        r_inst_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_inst       <= NOP_INST;
                        r_fault      <= 1'b1;
                        r_inst_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (pc_update) begin
                        r_pc         <= next_pc;
                        r_inst       <= NOP_INST;
                        r_fault      <= 1'b0;
                        r_inst_valid <= 1'b0;
                        r_cnt        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Self-checking bench for ifu_fetch: directed vector table
//                followed by randomized traffic against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] C_RPC  = 32'h8000_0000;
    localparam logic [31:0] C_NOP  = 32'h0000_0013;
    localparam int unsigned C_TOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic        pc_update;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        fetch_fault;

    int n_chk  = 0;
    int n_pass = 0;

    ifu_fetch #(
        .RESET_PC       (C_RPC),
        .TIMEOUT_CYCLES (C_TOUT),
        .NOP_INST       (C_NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc_update      (pc_update),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .pc             (pc),
        .instruction    (instruction),
        .inst_valid     (inst_valid),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        rerr, upd;
        logic [31:0] npc;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic        e_flt;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic re, input logic up, input logic [31:0] np,
                       input logic q, input logic [31:0] a, input logic iv,
                       input logic [31:0] ins, input logic f, input logic [31:0] p);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.rdata = rd; v.rerr = re; v.upd = up; v.npc = np;
        v.e_rqv = q; v.e_addr = a; v.e_iv = iv; v.e_inst = ins; v.e_flt = f; v.e_pc = p;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic q, input logic [31:0] a,
                             input logic iv, input logic [31:0] ins, input logic f,
                             input logic [31:0] p);
        check({tag, " req_valid"},   {31'd0, imem_req_valid}, {31'd0, q});
        check({tag, " req_addr"},    imem_req_addr, a);
        check({tag, " inst_valid"},  {31'd0, inst_valid}, {31'd0, iv});
        check({tag, " instruction"}, instruction, ins);
        check({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, f});
        check({tag, " pc"},          pc, p);
    endtask

    task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                         input logic re, input logic up, input logic [31:0] np);
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        imem_rsp_err = re; pc_update = up; next_pc = np;
    endtask

    // Transaction-level reference: a fetch is either pending (to be sent),
    // outstanding (sent, aging), or completed (a word is held for the core).
    logic [31:0] m_pc, m_inst;
    logic        m_pending, m_outstanding, m_held, m_fault;
    int          m_age;

    function automatic logic m_misaligned();
`ifdef IFU_ALIGN_CHECK_EN
        return m_pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] m_addr();
`ifdef IFU_ALIGN_CHECK_EN
        return m_pc;
`else
        return m_pc & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pc = C_RPC; m_inst = C_NOP; m_fault = 1'b0;
            m_pending = 1'b1; m_outstanding = 1'b0; m_held = 1'b0; m_age = 0;
        end else if (m_pending) begin
            if (m_misaligned()) begin
                m_pending = 1'b0; m_held = 1'b1; m_inst = C_NOP; m_fault = 1'b1;
            end else if (imem_req_ready) begin
                m_pending = 1'b0; m_outstanding = 1'b1; m_age = 0;
            end
        end else if (m_outstanding) begin
            m_age++;
            if (imem_rsp_valid) begin
                m_outstanding = 1'b0; m_held = 1'b1;
                m_inst = imem_rsp_err ? C_NOP : imem_rsp_data; m_fault = imem_rsp_err;
            end else if (m_age == int'(C_TOUT)) begin
                m_outstanding = 1'b0; m_held = 1'b1; m_inst = C_NOP; m_fault = 1'b1;
            end
        end else if (m_held && pc_update) begin
            m_pc = next_pc; m_held = 1'b0; m_inst = C_NOP; m_fault = 1'b0; m_pending = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a10, a20, a30, a40, a06, a08, w;
        a10 = 32'h8000_0010; a20 = 32'h8000_0020; a30 = 32'h8000_0030;
        a40 = 32'h8000_0040; a06 = 32'h8000_0006; a08 = 32'h8000_0008;

        // rst rdy rv data err upd npc | rqv addr iv inst flt pc
        add(1,0,0,0,0,0,0,                  0,C_RPC,0,C_NOP,0,C_RPC);
        add(0,1,0,0,0,0,0,                  1,C_RPC,0,C_NOP,0,C_RPC);
        add(0,0,1,32'h0010_0093,0,0,0,      0,C_RPC,0,C_NOP,0,C_RPC);
        add(0,0,0,0,0,0,0,                  0,C_RPC,1,32'h0010_0093,0,C_RPC);
        add(0,0,1,32'hDEAD_BEEF,0,0,0,      0,C_RPC,1,32'h0010_0093,0,C_RPC);
        add(0,0,0,0,0,1,a10,                0,C_RPC,1,32'h0010_0093,0,C_RPC);
        add(0,0,0,0,0,0,0,                  1,a10,0,C_NOP,0,a10);
        add(0,0,0,0,0,1,32'h8000_0100,      1,a10,0,C_NOP,0,a10);
        add(0,0,0,0,0,0,0,                  1,a10,0,C_NOP,0,a10);
        add(0,0,0,0,0,0,0,                  1,a10,0,C_NOP,0,a10);
        add(0,1,0,0,0,0,0,                  1,a10,0,C_NOP,0,a10);
        add(0,0,1,32'h1234_5678,1,0,0,      0,a10,0,C_NOP,0,a10);
        add(0,0,0,0,0,0,0,                  0,a10,1,C_NOP,1,a10);
        add(0,0,0,0,0,1,a20,                0,a10,1,C_NOP,1,a10);
        add(0,1,0,0,0,0,0,                  1,a20,0,C_NOP,0,a20);
        for (int i = 0; i < 4; i++)
            add(0,0,0,0,0,0,0,              0,a20,0,C_NOP,0,a20);
        add(0,0,1,32'hAAAA_5555,0,0,0,      0,a20,1,C_NOP,1,a20);
        add(0,0,0,0,0,1,a30,                0,a20,1,C_NOP,1,a20);
        add(0,1,0,0,0,0,0,                  1,a30,0,C_NOP,0,a30);
        for (int i = 0; i < 3; i++)
            add(0,0,0,0,0,0,0,              0,a30,0,C_NOP,0,a30);
        add(0,0,1,32'h0050_0293,0,0,0,      0,a30,0,C_NOP,0,a30);
        add(0,0,0,0,0,0,0,                  0,a30,1,32'h0050_0293,0,a30);
        add(0,0,0,0,0,1,a40,                0,a30,1,32'h0050_0293,0,a30);
        add(0,1,0,0,0,0,0,                  1,a40,0,C_NOP,0,a40);
        add(1,0,0,0,0,0,0,                  0,a40,0,C_NOP,0,a40);
        add(0,0,0,0,0,0,0,                  1,C_RPC,0,C_NOP,0,C_RPC);
        add(0,1,0,0,0,0,0,                  1,C_RPC,0,C_NOP,0,C_RPC);
        add(0,0,1,32'h0000_0011,0,0,0,      0,C_RPC,0,C_NOP,0,C_RPC);
        add(0,0,0,0,0,1,a06,                0,C_RPC,1,32'h0000_0011,0,C_RPC);
`ifdef IFU_ALIGN_CHECK_EN
        add(0,1,0,0,0,0,0,                  0,a06,0,C_NOP,0,a06);
        add(0,0,0,0,0,1,a08,                0,a06,1,C_NOP,1,a06);
        add(0,0,0,0,0,0,0,                  1,a08,0,C_NOP,0,a08);
`else
        add(0,0,0,0,0,0,0,                  1,32'h8000_0004,0,C_NOP,0,a06);
        add(0,1,0,0,0,0,0,                  1,32'h8000_0004,0,C_NOP,0,a06);
        add(0,0,1,32'h0000_0077,0,0,0,      0,32'h8000_0004,0,C_NOP,0,a06);
        add(0,0,0,0,0,0,0,                  0,32'h8000_0004,1,32'h0000_0077,0,a06);
`endif

        drive(1,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;

        // Directed vectors: inputs applied, outputs of that cycle checked, then clocked.
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rdata,
                  vecs[i].rerr, vecs[i].upd, vecs[i].npc);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_iv,
                      vecs[i].e_inst, vecs[i].e_flt, vecs[i].e_pc);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            w = $urandom();
            if ($urandom_range(7) != 0) w[1:0] = 2'b00;
            drive((c == 0) || ($urandom_range(199) == 0),
                  $urandom_range(1) == 1, $urandom_range(3) == 0, $urandom(),
                  $urandom_range(5) == 0, $urandom_range(2) == 0, w);
            #1;
            if (c > 0)
                check_all($sformatf("rnd%0d", c), !rst && m_pending && !m_misaligned(),
                          m_addr(), m_held, m_inst, m_fault, m_pc);
            model_step();
            @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
